rvl_ctrl_reg_bank: RTL

RVL_CTRL_REG_BANK -- requirements
Module: rvl_ctrl_reg_bank

---
 rtl/rvl_ctrl_reg_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/rvl_ctrl_reg_bank.sv
// Dual-port control register bank: an rvl port with read-only protection and
// error reporting, a privileged usr port, and sticky "rvl wrote" flags.
module rvl_ctrl_reg_bank #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                    usr_clk,
  input  logic                    usr_rst_n,
  input  logic                    rvl_ce,
  input  logic                    rvl_we,
  input  logic [ADDR_WIDTH-1:0]   rvl_addr,
  input  logic [DATA_WIDTH/8-1:0] rvl_be,
  input  logic [DATA_WIDTH-1:0]   rvl_wdata,
  output logic [DATA_WIDTH-1:0]   rvl_rdata,
  output logic                    rvl_rvalid,
  output logic                    rvl_err,
  input  logic                    usr_ce,
  input  logic                    usr_we,
  input  logic [ADDR_WIDTH-1:0]   usr_addr,
  input  logic [DATA_WIDTH/8-1:0] usr_be,
  input  logic [DATA_WIDTH-1:0]   usr_wdata,
  output logic [DATA_WIDTH-1:0]   usr_rdata,
  output logic                    usr_rvalid,
  output logic [NUM_REGS-1:0]     upd_flags,
  input  logic [NUM_REGS-1:0]     upd_clr
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   rvl_wsel;
  logic [NUM_REGS-1:0]   usr_wsel;
  logic                  rvl_in_range;
  logic                  usr_in_range;
  logic                  rvl_ro;
  logic [DATA_WIDTH-1:0] rvl_rd_mux;
  logic [DATA_WIDTH-1:0] usr_rd_mux;

  // Address decode; unimplemented addresses match nothing, so they read as 0.
  always_comb begin
    rvl_wsel     = '0;
    usr_wsel     = '0;
    rvl_in_range = 1'b0;
    usr_in_range = 1'b0;
    rvl_ro       = 1'b0;
    rvl_rd_mux   = '0;
    usr_rd_mux   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rvl_addr == ADDR_WIDTH'(i)) begin
        rvl_in_range = 1'b1;
        rvl_ro       = RO_MASK[i];
        rvl_rd_mux   = regs[i];
        rvl_wsel[i]  = rvl_ce & rvl_we & ~RO_MASK[i];
      end
      if (usr_addr == ADDR_WIDTH'(i)) begin
        usr_in_range = 1'b1;
        usr_rd_mux   = regs[i];
        usr_wsel[i]  = usr_ce & usr_we;
      end
    end
  end

  // rvl has byte priority; an RO register never selects rvl, so usr wins there.
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (rvl_wsel[i] && rvl_be[b])
            regs[i][b*8 +: 8] <= rvl_wdata[b*8 +: 8];
          else if (usr_wsel[i] && usr_be[b])
            regs[i][b*8 +: 8] <= usr_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      rvl_rdata  <= '0;
      rvl_rvalid <= 1'b0;
      rvl_err    <= 1'b0;
      usr_rdata  <= '0;
      usr_rvalid <= 1'b0;
    end else begin
      rvl_rvalid <= rvl_ce & ~rvl_we;
      usr_rvalid <= usr_ce & ~usr_we;
      if (rvl_ce && !rvl_we) rvl_rdata <= rvl_rd_mux;
      if (usr_ce && !usr_we) usr_rdata <= usr_rd_mux;
      rvl_err    <= rvl_ce & (~rvl_in_range | (rvl_we & rvl_ro));
    end
  end

  // Set dominates clear so a fresh write is never lost to a stale clear.
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n)
      upd_flags <= '0;
    else
      upd_flags <= (upd_flags & ~upd_clr) | (rvl_wsel & {NUM_REGS{|rvl_be}});
  end

endmodule
